// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard and a registered pending-producer count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data and busy-clear to the read ports.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   WriteAddr,
    input  logic [XLEN-1:0] WriteData,
    input  logic            ReadReg1,
    input  logic            ReadReg2,
    input  logic [AW-1:0]   ReadAddr1,
    input  logic [AW-1:0]   ReadAddr2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     pending_cnt
);

    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     pending_cnt_q;
    logic [AW:0]     pending_cnt_d;
    logic            cnt_inc;
    logic            cnt_dec;

    // Issue is applied after write-back so a same-edge issue to the same register wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we && WriteAddr != '0) begin
            regs_d[WriteAddr] = WriteData;
            busy_d[WriteAddr] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        // Only the issue target can rise and only the write-back target can fall, so the
        // population count moves by at most one in each direction per edge.
        cnt_inc = busy_d[issue_rd] & ~busy_q[issue_rd];
        cnt_dec = busy_q[WriteAddr] & ~busy_d[WriteAddr];
        pending_cnt_d = pending_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    logic            ren   [2];
    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];
    logic            rbusy [2];

    assign ren[0]   = ReadReg1;
    assign ren[1]   = ReadReg2;
    assign raddr[0] = ReadAddr1;
    assign raddr[1] = ReadAddr2;

    // Read ports are held at zero during reset so the bypass path cannot leak WriteData.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (!rst && ren[p] && raddr[p] != '0) begin
                rdata[p] = regs_q[raddr[p]];
                rbusy[p] = busy_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
                if (we && WriteAddr == raddr[p]) begin
                    rdata[p] = WriteData;
                    rbusy[p] = issue_valid && (issue_rd == raddr[p]);
                end
`endif
            end
        end
    end

    assign ReadData1   = rdata[0];
    assign ReadData2   = rdata[1];
    assign busy1       = rbusy[0];
    assign busy2       = rbusy[1];
    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based reference model.
// Honours REGFILE_BYPASS_EN in its expectations when the macro is defined.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic            clk;
    logic            rst;
    logic            we;
    logic [AW-1:0]   WriteAddr;
    logic [XLEN-1:0] WriteData;
    logic            ReadReg1;
    logic            ReadReg2;
    logic [AW-1:0]   ReadAddr1;
    logic [AW-1:0]   ReadAddr2;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            busy1;
    logic            busy2;
    logic [AW:0]     pending_cnt;

    int total;
    int bad;

    logic [XLEN-1:0] model_regs [NREG];
    bit              model_busy [NREG];

    regfile_sb #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy1(busy1), .busy2(busy2), .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            model_regs[i] = '0;
            model_busy[i] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += model_busy[i] ? 1 : 0;
        return n;
    endfunction

    // Expected combinational read for the current inputs, before the coming edge.
    function automatic logic [XLEN-1:0] model_read(input logic en, input logic [AW-1:0] a);
        if (rst || !en || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && WriteAddr == a) return WriteData;
`endif
        return model_regs[a];
    endfunction

    function automatic logic model_busy_rd(input logic en, input logic [AW-1:0] a);
        if (rst || !en || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && WriteAddr == a) return issue_valid && issue_rd == a;
`endif
        return model_busy[a];
    endfunction

    task automatic set_idle();
        we = 0; WriteAddr = '0; WriteData = '0;
        issue_valid = 0; issue_rd = '0;
        ReadReg1 = 0; ReadReg2 = 0; ReadAddr1 = '0; ReadAddr2 = '0;
    endtask

    // Advance one rising edge, applying the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (we && WriteAddr != 0) begin
                model_regs[WriteAddr] = WriteData;
                model_busy[WriteAddr] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) model_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; set_idle(); model_clear();
        #3;
        ReadReg1 = 1; ReadAddr1 = 5'd3; ReadReg2 = 1; ReadAddr2 = 5'd17;
        we = 1; WriteAddr = 5'd3; WriteData = 32'hCAFE_0001; issue_valid = 1; issue_rd = 5'd3;
        tick();
        total++;
        if (ReadData1 !== '0 || ReadData2 !== '0) begin
            bad++; $display("FAIL reset_hold_rdata: got %h/%h want 0/0", ReadData1, ReadData2);
        end
        total++;
        if (busy1 !== 1'b0 || pending_cnt !== '0) begin
            bad++; $display("FAIL reset_hold_busy: busy1=%b cnt=%0d want 0/0", busy1, pending_cnt);
        end
        @(negedge clk); set_idle(); rst = 0;
        ReadReg1 = 1;
        for (int a = 0; a < NREG; a++) begin
            ReadAddr1 = a[AW-1:0];
            #1;
            total++;
            if (ReadData1 !== '0) begin
                bad++; $display("FAIL reset_read_x%0d: got %h want 0", a, ReadData1);
            end
        end
        total++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || pending_cnt !== '0) begin
            bad++; $display("FAIL reset_flags: busy=%b%b cnt=%0d want 00/0", busy1, busy2, pending_cnt);
        end
    endtask

    task automatic test_write_x0();
        @(negedge clk); set_idle();
        we = 1; WriteAddr = '0; WriteData = 32'hDEAD_BEEF; issue_valid = 1; issue_rd = '0;
        tick();
        @(negedge clk); set_idle(); ReadReg1 = 1; ReadAddr1 = '0;
        #1;
        total++;
        if (ReadData1 !== '0 || busy1 !== 1'b0 || pending_cnt !== '0) begin
            bad++; $display("FAIL write_x0: data=%h busy=%b cnt=%0d want 0/0/0", ReadData1, busy1, pending_cnt);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); set_idle(); issue_valid = 1; issue_rd = 5'd5;
        tick();
        @(negedge clk); set_idle(); ReadReg1 = 1; ReadAddr1 = 5'd5;
        #1;
        total++;
        if (busy1 !== 1'b1 || pending_cnt !== 6'd1) begin
            bad++; $display("FAIL sb_issue: busy1=%b cnt=%0d want 1/1", busy1, pending_cnt);
        end
        @(negedge clk); we = 1; WriteAddr = 5'd5; WriteData = 32'h1234;
        tick();
        @(negedge clk); we = 0;
        #1;
        total++;
        if (busy1 !== 1'b0 || ReadData1 !== 32'h1234 || pending_cnt !== '0) begin
            bad++; $display("FAIL sb_writeback: busy1=%b data=%h cnt=%0d want 0/00001234/0", busy1, ReadData1, pending_cnt);
        end
        // Write-back to an idle register updates data and leaves the flag clear.
        we = 1; WriteAddr = 5'd6; WriteData = 32'h6666_0000;
        tick();
        @(negedge clk); set_idle(); ReadReg2 = 1; ReadAddr2 = 5'd6;
        #1;
        total++;
        if (busy2 !== 1'b0 || ReadData2 !== 32'h6666_0000 || pending_cnt !== '0) begin
            bad++; $display("FAIL sb_idle_wb: busy2=%b data=%h cnt=%0d want 0/66660000/0", busy2, ReadData2, pending_cnt);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); set_idle(); issue_valid = 1; issue_rd = 5'd7;
        tick();
        @(negedge clk); issue_valid = 1; issue_rd = 5'd7;
        we = 1; WriteAddr = 5'd7; WriteData = 32'h7777_7777;
        tick();
        @(negedge clk); set_idle(); ReadReg1 = 1; ReadAddr1 = 5'd7;
        #1;
        total++;
        if (busy1 !== 1'b1 || ReadData1 !== 32'h7777_7777 || pending_cnt !== 6'd1) begin
            bad++; $display("FAIL simul_x7: busy1=%b data=%h cnt=%0d want 1/77777777/1", busy1, ReadData1, pending_cnt);
        end
        // Re-issue to an already busy register keeps a single mark.
        issue_valid = 1; issue_rd = 5'd7;
        tick();
        @(negedge clk); issue_valid = 0;
        #1;
        total++;
        if (pending_cnt !== 6'd1) begin
            bad++; $display("FAIL reissue_x7: cnt=%0d want 1", pending_cnt);
        end
        we = 1; WriteAddr = 5'd7; WriteData = 32'h7;
        tick();
        @(negedge clk); set_idle();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want;
        @(negedge clk); set_idle(); we = 1; WriteAddr = 5'd3; WriteData = 32'h1111_1111;
        issue_valid = 1; issue_rd = 5'd3;
        tick();
        @(negedge clk); set_idle();
        we = 1; WriteAddr = 5'd3; WriteData = 32'hA5A5_A5A5;
        ReadReg1 = 1; ReadAddr1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'hA5A5_A5A5;
`else
        want = 32'h1111_1111;
`endif
        total++;
        if (ReadData1 !== want) begin
            bad++; $display("FAIL bypass_data_x3: got %h want %h", ReadData1, want);
        end
        total++;
`ifdef REGFILE_BYPASS_EN
        if (busy1 !== 1'b0) begin
            bad++; $display("FAIL bypass_busy_x3: got %b want 0", busy1);
        end
`else
        if (busy1 !== 1'b1) begin
            bad++; $display("FAIL bypass_busy_x3: got %b want 1", busy1);
        end
`endif
        tick();
        @(negedge clk); set_idle();
    endtask

    task automatic test_fill();
        for (int r = 1; r < NREG; r++) begin
            @(negedge clk); set_idle(); issue_valid = 1; issue_rd = r[AW-1:0];
            tick();
        end
        @(negedge clk); set_idle();
        #1;
        total++;
        if (pending_cnt !== 6'(NREG - 1)) begin
            bad++; $display("FAIL fill_max: cnt=%0d want %0d", pending_cnt, NREG - 1);
        end
        for (int r = 1; r < NREG; r++) begin
            @(negedge clk); set_idle(); we = 1; WriteAddr = r[AW-1:0]; WriteData = $urandom;
            tick();
        end
        @(negedge clk); set_idle();
        #1;
        total++;
        if (pending_cnt !== '0) begin
            bad++; $display("FAIL drain_zero: cnt=%0d want 0", pending_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); set_idle(); we = 1; WriteAddr = 5'd9; WriteData = 32'h9999_0009;
        tick();
        @(negedge clk); set_idle(); issue_valid = 1; issue_rd = 5'd9;
        tick();
        set_idle(); ReadReg1 = 1; ReadAddr1 = 5'd9;
        #2;
        rst = 1; model_clear();
        #1;
        total++;
        if (pending_cnt !== '0 || busy1 !== 1'b0 || ReadData1 !== '0) begin
            bad++; $display("FAIL async_rst_x9: cnt=%0d busy1=%b data=%h want 0/0/0", pending_cnt, busy1, ReadData1);
        end
        @(negedge clk); we = 1; WriteAddr = 5'd9; WriteData = 32'hFFFF_FFFF;
        issue_valid = 1; issue_rd = 5'd9;
        tick();
        @(negedge clk); set_idle(); rst = 0; ReadReg1 = 1; ReadAddr1 = 5'd9;
        #1;
        total++;
        if (pending_cnt !== '0 || busy1 !== 1'b0 || ReadData1 !== '0) begin
            bad++; $display("FAIL post_rst_x9: cnt=%0d busy1=%b data=%h want 0/0/0", pending_cnt, busy1, ReadData1);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] e1, e2;
        logic            eb1, eb2;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we          = $urandom_range(0, 1);
            WriteAddr   = AW'($urandom_range(0, 7));
            WriteData   = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rd    = AW'($urandom_range(0, 7));
            ReadReg1    = $urandom_range(0, 3) != 0;
            ReadReg2    = $urandom_range(0, 3) != 0;
            ReadAddr1   = ($urandom_range(0, 1) != 0) ? WriteAddr : AW'($urandom_range(0, 7));
            ReadAddr2   = AW'($urandom_range(0, NREG - 1));
            #1;
            e1 = model_read(ReadReg1, ReadAddr1);
            e2 = model_read(ReadReg2, ReadAddr2);
            eb1 = model_busy_rd(ReadReg1, ReadAddr1);
            eb2 = model_busy_rd(ReadReg2, ReadAddr2);
            total++;
            if (ReadData1 !== e1 || ReadData2 !== e2) begin
                bad++; $display("FAIL rand_rdata c=%0d: got %h/%h want %h/%h", c, ReadData1, ReadData2, e1, e2);
            end
            total++;
            if (busy1 !== eb1 || busy2 !== eb2) begin
                bad++; $display("FAIL rand_busy c=%0d: got %b%b want %b%b", c, busy1, busy2, eb1, eb2);
            end
            tick();
            total++;
            if (pending_cnt !== 6'(model_count())) begin
                bad++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, pending_cnt, model_count());
            end
        end
        @(negedge clk); set_idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_write_x0();
        test_scoreboard();
        test_simultaneous();
        test_bypass();
        test_fill();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL take parameter XLEN, default 32: data width of each register.
REQ-002 SHALL take parameter AW, default 5: address width; the register count is NREG = 2^AW.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port we, input, 1: write-back enable.
REQ-006 SHALL have port WriteAddr, input, AW: write-back destination register.
REQ-007 SHALL have port WriteData, input, XLEN: write-back data.
REQ-008 SHALL have ports ReadReg1 and ReadReg2, input, 1 each: read-port enables.
REQ-009 SHALL have ports ReadAddr1 and ReadAddr2, input, AW each: read-port source registers.
REQ-010 SHALL have ports ReadData1 and ReadData2, output, XLEN each: read-port data.
REQ-011 SHALL have port issue_valid, input, 1: an instruction with a destination register issues this cycle.
REQ-012 SHALL have port issue_rd, input, AW: destination register of the issuing instruction.
REQ-013 SHALL have ports busy1 and busy2, output, 1 each: the addressed source register has a write pending.
REQ-014 SHALL have port pending_cnt, output, AW+1: number of registers currently marked busy.

Function
REQ-015 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be marked busy.
REQ-016 Writes SHALL be synchronous: when we=1 and WriteAddr!=0, regs[WriteAddr] takes WriteData at the rising edge.
REQ-017 Reads SHALL be combinational: ReadDataN = regs[ReadAddrN] when ReadRegN=1, and 0 when ReadRegN=0 or ReadAddrN=0.
REQ-018 Each register SHALL have a one-bit busy flag: set at the edge when issue_valid=1 and issue_rd=r (r!=0); cleared at the edge when we=1 and WriteAddr=r.
REQ-019 Simultaneous issue and write-back to the same r SHALL leave busy[r]=1 (the new producer wins); the data write still occurs.
REQ-020 Issue to a register that is already busy SHALL leave it busy; no count of producers is kept.
REQ-021 Write-back to a register that is not busy SHALL update the data and leave busy at 0; this is not an error.
REQ-022 busyN SHALL equal busy[ReadAddrN] when ReadRegN=1 and ReadAddrN!=0, and 0 otherwise; combinational.
REQ-023 pending_cnt SHALL be a registered population count of the busy flags, updated in the same edge as the flags, with step +1, -1 or 0.
REQ-024 pending_cnt SHALL have range 0..NREG-1 and SHALL never wrap.

Reset
REQ-025 Asserting rst SHALL immediately clear all registers, busy flags and pending_cnt, without waiting for a clock edge.
REQ-026 While rst=1, ReadData1/2, busy1/2 and pending_cnt SHALL read 0, and we and issue_valid SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard all pending writes; the first edge after release SHALL behave as from power-up.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined:
- When we=1 and WriteAddr=ReadAddrN!=0, ReadDataN SHALL return WriteData in the same cycle.
- busyN SHALL read 0 for that address, unless issue_valid=1 and issue_rd=ReadAddrN in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN: ReadDataN SHALL return the pre-write value, and busyN SHALL reflect the flag before the edge.

Verification
REQ-030 Reset then reset release: rst=1 then 0 -> ReadData1=0 for all addresses, busy1=busy2=0, pending_cnt=0.
REQ-031 Write x0: we=1, WriteAddr=0, WriteData=0xDEADBEEF -> ReadData1 at addr 0 is 0 next cycle.
REQ-032 Scoreboard: issue rd=5 -> busy1(addr 5)=1 and pending_cnt=1; write-back x5=0x1234 -> busy1=0, ReadData1=0x1234, pending_cnt=0.
REQ-033 Simultaneous issue and write-back to x7 -> busy[7] stays 1, regs[7] updated, pending_cnt unchanged.
REQ-034 Same-cycle read of x3 while writing 0xA5A5A5A5 -> bypass build returns 0xA5A5A5A5; non-bypass build returns the old value.
REQ-035 Issue x9 then assert rst asynchronously mid-cycle -> pending_cnt=0 and busy=0 before the next edge; ReadData of x9 is 0.
